// File: rtl/reg_word_serializer.sv
// -----------------------------------------------------------------------------
// reg_word_serializer
//
// Parallel-in, serial-out reader for an N-bit register word. A load request
// captures the whole word into a shadow register. The word is then drained as
// BEATS = N/W chunks of W bits over a valid/ready stream, least-significant
// chunk first.
//
// Handshake: a chunk transfers on a rising edge where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0, out_data and out_last stay
// unchanged. out_valid never depends on out_ready.
//
// Parameters:
//   N  - captured word width; must be an integer multiple of W
//   W  - output chunk width
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   load       in   capture request, sampled at the rising edge
//   D          in   N-bit word, captured when a load is accepted
//   out_ready  in   downstream accepts the current chunk
//   out_valid  out  out_data holds a valid chunk
//   out_data   out  current W-bit chunk
//   out_last   out  current chunk is the final beat of the frame
//   busy       out  frame in progress; loads are not accepted
//   drop       out  one-cycle pulse after a load that arrived while busy
// -----------------------------------------------------------------------------
module reg_word_serializer #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] D,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic         drop
);

   localparam int BEATS = N / W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

   generate
      if (W < 1 || N < W || (N % W) != 0) begin : g_bad_params
         $error("reg_word_serializer: N must be a positive multiple of W");
      end
   endgenerate

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [BW-1:0]  r_beat;
   logic [N-1:0]   r_shadow;
   logic           r_drop;
   logic           w_accept;
   logic           w_hs;
   logic           w_hs_last;

   // Next-state and transfer decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_hs        = 1'b0;
      w_hs_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (load) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            w_hs      = out_ready;
            w_hs_last = out_ready && (r_beat == BEAT_LAST);
            if (w_hs_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and datapath. The shadow register shifts right by one
   // chunk per non-final handshake, so the current chunk is always in its low
   // W bits. Without a handshake nothing in here changes, which keeps the
   // presented chunk stable during stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_beat   <= '0;
         r_shadow <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // A load seen while a frame is in progress (including the final
         // handshake edge) is discarded and reported one cycle later.
         r_drop  <= load && (r_state == S_SEND);
         if (w_accept) begin
            r_shadow <= D;
            r_beat   <= '0;
         end else if (w_hs_last) begin
            r_beat   <= '0;
         end else if (w_hs) begin
            r_beat   <= r_beat + BEAT_ONE;
            r_shadow <= r_shadow >> W;
         end
      end
   end

   // Every output is decoded from registers only.
   assign busy      = (r_state == S_SEND);
   assign out_valid = (r_state == S_SEND);
   assign out_data  = r_shadow[W-1:0];
   assign out_last  = (r_state == S_SEND) && (r_beat == BEAT_LAST);
   assign drop      = r_drop;

endmodule

// File: tb/tb_reg_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_reg_word_serializer
//
// Directed bench for reg_word_serializer. It builds two instances: N=32/W=8 for
// the multi-beat cases and N=8/W=8 for the single-beat case. Stimulus pushes
// the expected {last, chunk} pairs into a queue. A monitor pops and compares
// them on every handshake, and checks held chunks during stalls.
// -----------------------------------------------------------------------------
module tb_reg_word_serializer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT: N=32, W=8 ----------------
   logic        load      = 1'b0;
   logic [31:0] d         = '0;
   logic        out_ready = 1'b0;
   logic        ov;
   logic [7:0]  od;
   logic        ol;
   logic        bsy;
   logic        drp;

   reg_word_serializer #(.N(32), .W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .D         (d),
      .out_ready (out_ready),
      .out_valid (ov),
      .out_data  (od),
      .out_last  (ol),
      .busy      (bsy),
      .drop      (drp)
   );

   // ---------------- DUT: N=8, W=8 ----------------
   logic        load8 = 1'b0;
   logic [7:0]  d8    = '0;
   logic        rdy8  = 1'b0;
   logic        ov8;
   logic [7:0]  od8;
   logic        ol8;
   logic        bsy8;
   logic        drp8;

   reg_word_serializer #(.N(8), .W(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .load      (load8),
      .D         (d8),
      .out_ready (rdy8),
      .out_valid (ov8),
      .out_data  (od8),
      .out_last  (ol8),
      .busy      (bsy8),
      .drop      (drp8)
   );

   // ---------------- scoreboard state ----------------
   int         total  = 0;
   int         bad    = 0;
   int         hs_cnt = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp8_q[$];
   logic [8:0] mon_e;
   logic [8:0] mon8_e;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected chunks of a 32-bit word, LS chunk first, last flag on beat 3.
   task automatic push32(input logic [31:0] word);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({(i == 3), word[i*8 +: 8]});
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst && ov) begin
         if (out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_chunk actual=%h expected=none at %0t", {ol, od}, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("chunk", {55'd0, ol, od}, {55'd0, mon_e});
            end
         end else if (exp_q.size() != 0) begin
            chk("stall_hold", {55'd0, ol, od}, {55'd0, exp_q[0]});
         end
      end
   end

   always @(negedge clk) begin
      if (rst && ov8) begin
         if (rdy8) begin
            if (exp8_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_chunk8 actual=%h expected=none at %0t", {ol8, od8}, $time);
            end else begin
               mon8_e = exp8_q.pop_front();
               chk("chunk8", {55'd0, ol8, od8}, {55'd0, mon8_e});
            end
         end else if (exp8_q.size() != 0) begin
            chk("stall_hold8", {55'd0, ol8, od8}, {55'd0, exp8_q[0]});
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [6:0] pat;
   int         hs_before;

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_valid", ov, 1'b0);
      chk("rst_data",  od, 8'h00);
      chk("rst_last",  ol, 1'b0);
      chk("rst_busy",  bsy, 1'b0);
      chk("rst_drop",  drp, 1'b0);
      chk("rst_busy8", bsy8, 1'b0);
      rst = 1'b1;
      tick();

      // Back-to-back drain with out_ready held high
      push32(32'hA1B2C3D4);
      out_ready = 1'b1;
      d         = 32'hA1B2C3D4;
      load      = 1'b1;
      tick();
      load = 1'b0;
      chk("t1_busy_after_load",  bsy, 1'b1);
      chk("t1_valid_after_load", ov, 1'b1);
      chk("t1_first_chunk",      od, 8'hD4);
      for (int i = 0; i < 4; i++) tick();
      chk("t1_busy_done",  bsy, 1'b0);
      chk("t1_valid_done", ov, 1'b0);
      chk("t1_q_empty",    exp_q.size(), 0);

      // Stalls: out_ready = 1,0,0,1,0,1,1 (pat[0] first)
      out_ready = 1'b0;
      push32(32'hA1B2C3D4);
      hs_before = hs_cnt;
      load      = 1'b1;
      tick();
      load = 1'b0;
      pat  = 7'b1101001;
      for (int i = 0; i < 7; i++) begin
         out_ready = pat[i];
         tick();
      end
      chk("t2_handshakes", hs_cnt - hs_before, 4);
      chk("t2_busy_done",  bsy, 1'b0);
      chk("t2_q_empty",    exp_q.size(), 0);

      // Load every cycle: the second accepted word is 6, drops on edges t+1..t+4
      out_ready = 1'b1;
      push32(32'h00000001);
      push32(32'h00000006);
      for (int k = 0; k < 6; k++) begin
         d    = 32'(k + 1);
         load = 1'b1;
         tick();
         chk($sformatf("t3_drop_k%0d", k), drp, (k >= 1 && k <= 4));
      end
      load = 1'b0;
      tick();
      chk("t3_drop_after", drp, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk("t3_busy_done", bsy, 1'b0);
      chk("t3_q_empty",   exp_q.size(), 0);

      // D changing during SEND has no effect
      push32(32'h11223344);
      d    = 32'h11223344;
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         tick();
      end
      chk("t4_busy_done", bsy, 1'b0);
      chk("t4_q_empty",   exp_q.size(), 0);

      // Asynchronous reset mid-frame, then a fresh frame
      exp_q.push_back(9'h0EF);
      d    = 32'hDEADBEEF;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk("t5_mid_chunk", od, 8'hBE);
      rst = 1'b0;
      #1;
      chk("t5_rst_valid", ov, 1'b0);
      chk("t5_rst_data",  od, 8'h00);
      chk("t5_rst_last",  ol, 1'b0);
      chk("t5_rst_busy",  bsy, 1'b0);
      chk("t5_rst_drop",  drp, 1'b0);
      chk("t5_q_empty",   exp_q.size(), 0);
      tick();
      rst = 1'b1;
      push32(32'h12345678);
      d    = 32'h12345678;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("t5_busy_after_load", bsy, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      chk("t5_busy_done", bsy, 1'b0);
      chk("t5_q_empty2",  exp_q.size(), 0);

      // Single-beat instance
      exp8_q.push_back({1'b1, 8'h5A});
      rdy8  = 1'b1;
      d8    = 8'h5A;
      load8 = 1'b1;
      tick();
      load8 = 1'b0;
      chk("t6_busy",  bsy8, 1'b1);
      chk("t6_valid", ov8, 1'b1);
      chk("t6_last",  ol8, 1'b1);
      tick();
      chk("t6_busy_done", bsy8, 1'b0);
      exp8_q.push_back({1'b1, 8'hC3});
      rdy8  = 1'b0;
      d8    = 8'hC3;
      load8 = 1'b1;
      tick();
      load8 = 1'b0;
      tick();
      chk("t6_busy_stall", bsy8, 1'b1);
      rdy8 = 1'b1;
      tick();
      chk("t6_busy_done2", bsy8, 1'b0);
      chk("t6_q8_empty",   exp8_q.size(), 0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
